gt_2bit_tester: RTL

GT_2BIT_TESTER -- requirements
Module: gt_2bit_tester

---
 rtl/gt_2bit_tester.sv | 101 ++++++++++
 1 files changed

// File: rtl/gt_2bit_tester.sv
// Exhaustive self-test sequencer for a 2-bit greater-than comparator: sweeps all
// 16 {a,b} vectors and tallies mismatches. Optional macro: GT_TESTER_STOP_ON_FAIL_EN.
module gt_2bit_tester #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [1:0] a,
  output logic [1:0] b,
  input  logic       agtb_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [3:0] fail_vec,
  output logic [3:0] vec_idx
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_DRIVE  = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

  logic [2:0] state;
  logic [3:0] settle_cnt;
  logic       expected;
  logic       mismatch;
  logic       last_vec;

  // Operands come straight from the index so they are valid in every state.
  assign a        = vec_idx[3:2];
  assign b        = vec_idx[1:0];
  assign expected = (a > b);
  assign mismatch = (state == S_CHECK) && (agtb_in != expected);
  assign last_vec = (vec_idx == 4'd15);

  assign busy = (state == S_DRIVE) || (state == S_SETTLE) || (state == S_CHECK);
  assign done = (state == S_DONE);
  assign pass = done && (err_count == 5'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      settle_cnt <= 4'd0;
      err_count  <= 5'd0;
      fail_vec   <= 4'd0;
      vec_idx    <= 4'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            err_count <= 5'd0;
            fail_vec  <= 4'd0;
            vec_idx   <= 4'd0;
            state     <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          settle_cnt <= SETTLE_LD;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          // Counter was loaded with SETTLE_CYCLES, so leaving at 1 gives exactly that many cycles.
          if (settle_cnt <= 4'd1) begin
            settle_cnt <= 4'd0;
            state      <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            err_count <= err_count + 5'd1;
            if (err_count == 5'd0) fail_vec <= vec_idx;
          end
`ifdef GT_TESTER_STOP_ON_FAIL_EN
          if (mismatch || last_vec) begin
            state <= S_DONE;
          end else begin
            vec_idx <= vec_idx + 4'd1;
            state   <= S_DRIVE;
          end
`else
          if (last_vec) begin
            state <= S_DONE;
          end else begin
            vec_idx <= vec_idx + 4'd1;
            state   <= S_DRIVE;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
